// File: rtl/priority_encoder_16.sv
// 16-line active-low priority encoder with a synchronizer, a stability filter and 74148-style flags.
// New active codes are posted to a one-deep event register with a valid/ack handshake and a sticky overrun flag.
module priority_encoder_16 #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req_n,
  input  logic        ei_n,
  output logic [3:0]  code,
  output logic        gs_n,
  output logic        eo_n,
  output logic        evt_valid,
  output logic [3:0]  evt_code,
  input  logic        evt_ack,
  output logic        overrun
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [16:0] sync1_q, sample_q, prev_q, stable_q, stable_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        same_c;

  logic [15:0] act_c;
  logic [3:0]  hi_c;
  logic [3:0]  code_q, code_d;
  logic        gs_n_q, gs_n_d;
  logic        eo_n_q, eo_n_d;

  logic        event_c, accept_c;
  logic        evt_valid_q, evt_valid_d;
  logic [3:0]  evt_code_q, evt_code_d;
  logic        overrun_q, overrun_d;

  // Stability filter: the stable register only takes a sample that has been
  // seen unchanged on STABLE_CYCLES+1 consecutive edges.
  always_comb begin
    same_c   = (sample_q == prev_q);
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (!same_c) begin
      cnt_d = 8'd0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (same_c && (cnt_q == CNT_LAST)) begin
      stable_d = sample_q;
    end
  end

  // The encoder works from stable_d, so its registered outputs always equal
  // a function of the stable register, updated on the same edge.
  always_comb begin
    act_c = ~stable_d[15:0];
    hi_c  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (act_c[i]) begin
        hi_c = 4'(i);
      end
    end
  end

  always_comb begin
    code_d = 4'd0;
    gs_n_d = 1'b1;
    eo_n_d = 1'b1;
    if (!stable_d[16]) begin
      if (|act_c) begin
        code_d = hi_c;
        gs_n_d = 1'b0;
      end else begin
        eo_n_d = 1'b0;
      end
    end
  end

  // An event is a transition into an active code, or a change of active code.
  always_comb begin
    event_c     = !gs_n_d && (gs_n_q || (code_d != code_q));
    accept_c    = evt_ack && evt_valid_q;
    evt_valid_d = event_c || (evt_valid_q && !accept_c);
    evt_code_d  = event_c ? code_d : evt_code_q;
    overrun_d   = (event_c && evt_valid_q && !evt_ack) || (overrun_q && !accept_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= '1;
      sample_q    <= '1;
      prev_q      <= '1;
      stable_q    <= '1;
      cnt_q       <= 8'd0;
      code_q      <= 4'd0;
      gs_n_q      <= 1'b1;
      eo_n_q      <= 1'b1;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 4'd0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= {ei_n, req_n};
      sample_q    <= sync1_q;
      prev_q      <= sample_q;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      gs_n_q      <= gs_n_d;
      eo_n_q      <= eo_n_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      overrun_q   <= overrun_d;
    end
  end

  assign code      = code_q;
  assign gs_n      = gs_n_q;
  assign eo_n      = eo_n_q;
  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_priority_encoder_16.sv
// Directed bench for priority_encoder_16: inputs change on the falling edge,
// outputs are checked on the falling edge after the counted rising edges.
module tb_priority_encoder_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req_n;
  logic        ei_n;
  logic [3:0]  code;
  logic        gs_n;
  logic        eo_n;
  logic        evt_valid;
  logic [3:0]  evt_code;
  logic        evt_ack;
  logic        overrun;

  int checks = 0;
  int passed = 0;

  priority_encoder_16 #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_n     (req_n),
    .ei_n      (ei_n),
    .code      (code),
    .gs_n      (gs_n),
    .eo_n      (eo_n),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ack   (evt_ack),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
      $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack_pulse();
    evt_ack = 1'b1;
    tick(1);
    evt_ack = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    req_n   = 16'hFFFF;
    ei_n    = 1'b1;
    evt_ack = 1'b0;
    tick(3);
    chk("rst_code", 16'(code), 16'h0);
    chk("rst_gs_n", 16'(gs_n), 16'h1);
    chk("rst_eo_n", 16'(eo_n), 16'h1);
    chk("rst_valid", 16'(evt_valid), 16'h0);
    chk("rst_evt_code", 16'(evt_code), 16'h0);
    chk("rst_overrun", 16'(overrun), 16'h0);

    // 1: idle, enabled, nothing requested
    rst_n = 1'b1;
    ei_n  = 1'b0;
    tick(20);
    chk("idle_gs_n", 16'(gs_n), 16'h1);
    chk("idle_eo_n", 16'(eo_n), 16'h0);
    chk("idle_code", 16'(code), 16'h0);
    chk("idle_valid", 16'(evt_valid), 16'h0);

    // 2: line 3, exact 7-edge latency
    req_n = 16'hFFF7;
    tick(6);
    chk("lat6_gs_n", 16'(gs_n), 16'h1);
    chk("lat6_valid", 16'(evt_valid), 16'h0);
    tick(1);
    chk("lat7_code", 16'(code), 16'h3);
    chk("lat7_gs_n", 16'(gs_n), 16'h0);
    chk("lat7_eo_n", 16'(eo_n), 16'h1);
    chk("lat7_valid", 16'(evt_valid), 16'h1);
    chk("lat7_evt_code", 16'(evt_code), 16'h3);
    ack_pulse();
    chk("ack_valid", 16'(evt_valid), 16'h0);
    chk("ack_evt_code_hold", 16'(evt_code), 16'h3);
    ack_pulse();
    chk("idle_ack_valid", 16'(evt_valid), 16'h0);

    // 3: priority
    req_n = 16'h7FFE;
    tick(7);
    chk("prio_code", 16'(code), 16'hF);
    chk("prio_evt_code", 16'(evt_code), 16'hF);
    chk("prio_valid", 16'(evt_valid), 16'h1);
    ack_pulse();
    req_n = 16'h7F00;
    tick(8);
    chk("lower_chg_code", 16'(code), 16'hF);
    chk("lower_chg_valid", 16'(evt_valid), 16'h0);
    req_n = 16'hFFFE;
    tick(7);
    chk("rel15_code", 16'(code), 16'h0);
    chk("rel15_gs_n", 16'(gs_n), 16'h0);
    chk("rel15_valid", 16'(evt_valid), 16'h1);
    chk("rel15_evt_code", 16'(evt_code), 16'h0);
    ack_pulse();
    req_n = 16'hFFFF;
    tick(8);
    chk("release_gs_n", 16'(gs_n), 16'h1);
    chk("release_valid", 16'(evt_valid), 16'h0);

    // 4: glitch rejection, then acceptance at STABLE_CYCLES+1
    req_n = 16'hFDFF;
    tick(3);
    req_n = 16'hFFFF;
    tick(10);
    chk("glitch_gs_n", 16'(gs_n), 16'h1);
    chk("glitch_code", 16'(code), 16'h0);
    chk("glitch_valid", 16'(evt_valid), 16'h0);
    req_n = 16'hFDFF;
    tick(5);
    req_n = 16'hFFFF;
    tick(2);
    chk("hold5_code", 16'(code), 16'h9);
    chk("hold5_gs_n", 16'(gs_n), 16'h0);
    chk("hold5_evt_code", 16'(evt_code), 16'h9);
    tick(10);
    chk("hold5_release_gs_n", 16'(gs_n), 16'h1);
    ack_pulse();

    // 5: overrun and handshake corner cases
    req_n = 16'hFFFB;
    tick(7);
    chk("ovr_first_evt_code", 16'(evt_code), 16'h2);
    chk("ovr_first_overrun", 16'(overrun), 16'h0);
    req_n = 16'hFFDF;
    tick(7);
    chk("ovr_evt_code", 16'(evt_code), 16'h5);
    chk("ovr_overrun", 16'(overrun), 16'h1);
    chk("ovr_valid", 16'(evt_valid), 16'h1);
    ack_pulse();
    chk("ovr_ack_valid", 16'(evt_valid), 16'h0);
    chk("ovr_ack_overrun", 16'(overrun), 16'h0);
    req_n = 16'hFFEF;
    tick(7);
    chk("pend4_evt_code", 16'(evt_code), 16'h4);
    req_n = 16'hFFBF;
    tick(6);
    evt_ack = 1'b1;
    tick(1);
    evt_ack = 1'b0;
    chk("coinc_valid", 16'(evt_valid), 16'h1);
    chk("coinc_evt_code", 16'(evt_code), 16'h6);
    chk("coinc_overrun", 16'(overrun), 16'h0);
    ack_pulse();

    // 6: disable, then reset while an event is pending
    ei_n = 1'b1;
    tick(6);
    chk("dis6_gs_n", 16'(gs_n), 16'h0);
    tick(1);
    chk("dis_gs_n", 16'(gs_n), 16'h1);
    chk("dis_eo_n", 16'(eo_n), 16'h1);
    chk("dis_code", 16'(code), 16'h0);
    chk("dis_valid", 16'(evt_valid), 16'h0);
    ei_n = 1'b0;
    tick(7);
    chk("reen_valid", 16'(evt_valid), 16'h1);
    chk("reen_code", 16'(code), 16'h6);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("mid_rst_code", 16'(code), 16'h0);
    chk("mid_rst_gs_n", 16'(gs_n), 16'h1);
    chk("mid_rst_eo_n", 16'(eo_n), 16'h1);
    chk("mid_rst_valid", 16'(evt_valid), 16'h0);
    chk("mid_rst_evt_code", 16'(evt_code), 16'h0);
    chk("mid_rst_overrun", 16'(overrun), 16'h0);
    tick(7);
    chk("post_rst_code", 16'(code), 16'h6);
    chk("post_rst_valid", 16'(evt_valid), 16'h1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
